// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package ctrl_pkg;

   localparam int unsigned OPC_W = 7;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR_CALC,
      S_JALR_JUMP,
      S_ILLEGAL
   } t_state;

   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

   localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
   localparam logic [SEL_W-1:0] RES_RDATA   = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;
   localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1    = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_RS2    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;
   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

   // State-only control values; handshake/flag gating is applied by the FSM
   typedef struct packed {
      logic             mem_req;
      logic             mem_write;
      logic             adr_src;
      logic             reg_write;
      logic             pc_write;
      logic             instr_done;
      logic [SEL_W-1:0] result_src;
      logic [SEL_W-1:0] alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      logic [SEL_W-1:0] alu_op;
   } t_ctrl;

endpackage

// File: rtl/ctrl_out_decoder.sv
// Combinational state-to-control table for the multi-cycle control FSM.
// ILLEGAL_INSTR_TRAP_EN: when defined, the ILLEGAL state retires nothing.
module ctrl_out_decoder
   import ctrl_pkg::*;
(
   input  t_state state,
   output t_ctrl  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req    = 1'b1;
            ctrl.alu_src_a  = SRCA_PC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMADR, S_JALR_CALC: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            ctrl.mem_req = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_RDATA;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.adr_src   = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_RS2;
            ctrl.alu_op     = ALUOP_SUB;
            ctrl.instr_done = 1'b1;
         end
         S_JAL, S_JALR_JUMP: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.pc_write  = 1'b1;
         end
         S_ILLEGAL: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
            ctrl = '0;
`else
            ctrl.instr_done = 1'b1;
`endif
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction
// and owns PC-write logic. ILLEGAL_INSTR_TRAP_EN makes illegal opcodes terminal.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_WIDTH    = 7,
   parameter int unsigned FUNC3_WIDTH = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [OP_WIDTH-1:0]    i_op,
   input  logic [FUNC3_WIDTH-1:0] i_func3,
   input  logic                   i_zero,
   input  logic                   i_mem_ready,
   output logic                   o_mem_req,
   output logic                   o_mem_write,
   output logic                   o_adr_src,
   output logic                   o_ir_write,
   output logic                   o_pc_write,
   output logic                   o_reg_write,
   output logic [1:0]             o_result_src,
   output logic [1:0]             o_alu_src_a,
   output logic [1:0]             o_alu_src_b,
   output logic [1:0]             o_alu_op,
   output logic                   o_instr_done,
   output logic                   o_illegal
);

   t_state state;
   t_state state_next;
   t_ctrl  ctrl;
   logic   taken;
   logic   unused_func3;

   assign taken        = i_zero ^ i_func3[0];
   assign unused_func3 = ^i_func3;

   ctrl_out_decoder u_dec (
      .state (state),
      .ctrl  (ctrl)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= S_FETCH;
      else          state <= state_next;
   end

   always_comb begin
      state_next   = state;
      o_mem_req    = ctrl.mem_req;
      o_mem_write  = ctrl.mem_write;
      o_adr_src    = ctrl.adr_src;
      o_ir_write   = 1'b0;
      o_pc_write   = ctrl.pc_write;
      o_reg_write  = ctrl.reg_write;
      o_result_src = ctrl.result_src;
      o_alu_src_a  = ctrl.alu_src_a;
      o_alu_src_b  = ctrl.alu_src_b;
      o_alu_op     = ctrl.alu_op;
      o_instr_done = ctrl.instr_done;
      o_illegal    = 1'b0;

      case (state)
         S_FETCH: begin
            if (i_mem_ready) begin
               o_ir_write = 1'b1;
               o_pc_write = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            case (i_op)
               OP_WIDTH'(OP_LOAD),
               OP_WIDTH'(OP_STORE):  state_next = S_MEMADR;
               OP_WIDTH'(OP_R):      state_next = S_EXEC_R;
               OP_WIDTH'(OP_I):      state_next = S_EXEC_I;
               OP_WIDTH'(OP_BRANCH): state_next = S_BRANCH;
               OP_WIDTH'(OP_JAL):    state_next = S_JAL;
               OP_WIDTH'(OP_JALR):   state_next = S_JALR_CALC;
               default:              state_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR:    state_next = i_op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:   if (i_mem_ready) state_next = S_MEMWB;
         S_MEMWB:     state_next = S_FETCH;
         S_MEMWRITE: begin
            if (i_mem_ready) begin
               o_instr_done = 1'b1;
               state_next   = S_FETCH;
            end
         end
         S_EXEC_R, S_EXEC_I: state_next = S_ALUWB;
         S_ALUWB:     state_next = S_FETCH;
         S_BRANCH: begin
            o_pc_write = taken;
            state_next = S_FETCH;
         end
         S_JAL:       state_next = S_ALUWB;
         S_JALR_CALC: state_next = S_JALR_JUMP;
         S_JALR_JUMP: state_next = S_ALUWB;
         S_ILLEGAL: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
            o_illegal  = 1'b1;
            state_next = S_ILLEGAL;
`else
            state_next = S_FETCH;
`endif
         end
         default:     state_next = S_FETCH;
      endcase

      // Reset abandons any in-flight instruction without side effects
      if (!i_rst_n) begin
         o_mem_req    = 1'b0;
         o_mem_write  = 1'b0;
         o_ir_write   = 1'b0;
         o_pc_write   = 1'b0;
         o_reg_write  = 1'b0;
         o_instr_done = 1'b0;
         o_illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: an instruction-level model expands
// each instruction into its expected per-cycle control vectors.
module tb_multicycle_ctrl_fsm;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [6:0] i_op;
   logic [2:0] i_func3;
   logic       i_zero;
   logic       i_mem_ready;
   logic       o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write;
   logic       o_reg_write, o_instr_done, o_illegal;
   logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op;

   int checks = 0;
   int fails  = 0;

   typedef struct packed {
      logic        rdy;
      logic [15:0] o;
   } t_step;

   t_step q[$];

   multicycle_ctrl_fsm #(.OP_WIDTH(7), .FUNC3_WIDTH(3)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_op         (i_op),
      .i_func3      (i_func3),
      .i_zero       (i_zero),
      .i_mem_ready  (i_mem_ready),
      .o_mem_req    (o_mem_req),
      .o_mem_write  (o_mem_write),
      .o_adr_src    (o_adr_src),
      .o_ir_write   (o_ir_write),
      .o_pc_write   (o_pc_write),
      .o_reg_write  (o_reg_write),
      .o_result_src (o_result_src),
      .o_alu_src_a  (o_alu_src_a),
      .o_alu_src_b  (o_alu_src_b),
      .o_alu_op     (o_alu_op),
      .o_instr_done (o_instr_done),
      .o_illegal    (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   // Vector layout: req wr adr irw pcw rw res[2] a[2] b[2] aop[2] done ill
   function automatic logic [15:0] vec(input logic req, wr, adr, irw, pcw, rw,
                                       input logic [1:0] res, a, b, aop,
                                       input logic done, ill);
      return {req, wr, adr, irw, pcw, rw, res, a, b, aop, done, ill};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write,
              o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_instr_done, o_illegal};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void push(input logic rdy, input logic [15:0] o);
      t_step s;
      s.rdy = rdy;
      s.o   = o;
      q.push_back(s);
   endfunction

   // Expand one instruction into the cycle sequence it must produce
   function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                 input int fw, input int mw);
      logic [15:0] aluwb;
      logic [15:0] memadr;
      aluwb  = vec(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
      memadr = vec(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0);
      for (int k = 0; k < fw; k++) push(1'b0, vec(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0));
      push(1'b1, vec(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00, 0,0));
      push(1'b1, vec(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0));
      case (op)
         7'b0000011: begin
            push(1'b1, memadr);
            for (int k = 0; k < mw; k++) push(1'b0, vec(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
            push(1'b1, vec(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
            push(1'b1, vec(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 1,0));
         end
         7'b0100011: begin
            push(1'b1, memadr);
            for (int k = 0; k < mw; k++) push(1'b0, vec(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
            push(1'b1, vec(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0));
         end
         7'b0110011: begin
            push(1'b0, vec(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0));
            push(1'b1, aluwb);
         end
         7'b0010011: begin
            push(1'b1, vec(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 0,0));
            push(1'b0, aluwb);
         end
         7'b1100011: push(1'b1, vec(0,0,0,0,z ^ f3[0],0, 2'b00,2'b10,2'b00,2'b01, 1,0));
         7'b1101111: begin
            push(1'b1, vec(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00, 0,0));
            push(1'b1, aluwb);
         end
         7'b1100111: begin
            push(1'b1, vec(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0));
            push(1'b1, vec(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00, 0,0));
            push(1'b1, aluwb);
         end
         default: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
            for (int k = 0; k < 5; k++) push(1'b1, vec(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1));
`else
            push(1'b1, vec(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0));
`endif
         end
      endcase
   endfunction

   task automatic reset_seq();
      i_rst_n     = 1'b0;
      i_mem_ready = 1'b1;
      repeat (3) begin
         @(negedge i_clk);
         check("reset strobes",
               {o_pc_write, o_ir_write, o_reg_write, o_mem_write, o_mem_req, o_instr_done, o_illegal},
               32'h0);
      end
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
   endtask

   // Drive up to nsteps of the model sequence, comparing every cycle
   task automatic drive(input string nm, input int nsteps, output int rw, output int pcw, output int done);
      rw = 0; pcw = 0; done = 0;
      for (int k = 0; k < nsteps && k < q.size(); k++) begin
         i_mem_ready = q[k].rdy;
         @(negedge i_clk);
         check($sformatf("%s cyc%0d", nm, k), 32'(dut_vec()), 32'(q[k].o));
         rw   += int'(o_reg_write);
         pcw  += int'(o_pc_write);
         done += int'(o_instr_done);
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic z,
                      input int fw, input int mw,
                      input int exp_len, input int exp_rw, input int exp_pcw, input int exp_done);
      int rw, pcw, done;
      q.delete();
      build(op, f3, z, fw, mw);
      check({nm, " length"}, 32'(q.size()), 32'(exp_len));
      i_op = op; i_func3 = f3; i_zero = z;
      drive(nm, q.size(), rw, pcw, done);
      check({nm, " reg_write count"}, 32'(rw), 32'(exp_rw));
      check({nm, " pc_write count"},  32'(pcw), 32'(exp_pcw));
      check({nm, " retire count"},    32'(done), 32'(exp_done));
   endtask

   initial begin
      int rw, pcw, done;
      i_op = 7'b0110011; i_func3 = 3'b000; i_zero = 1'b0;
      reset_seq();
      run("rtype",     7'b0110011, 3'b000, 1'b0, 0, 0, 4, 1, 1, 1);
      run("load_w2",   7'b0000011, 3'b010, 1'b0, 0, 2, 7, 1, 1, 1);
      run("itype_fw2", 7'b0010011, 3'b000, 1'b1, 2, 0, 6, 1, 1, 1);
      run("store_w1",  7'b0100011, 3'b010, 1'b0, 0, 1, 5, 0, 1, 1);
      run("bne_z0",    7'b1100011, 3'b001, 1'b0, 0, 0, 3, 0, 2, 1);
      run("bne_z1",    7'b1100011, 3'b001, 1'b1, 0, 0, 3, 0, 1, 1);
      run("beq_z1",    7'b1100011, 3'b000, 1'b1, 0, 0, 3, 0, 2, 1);
      run("jal",       7'b1101111, 3'b000, 1'b0, 0, 0, 4, 1, 2, 1);
      run("jalr",      7'b1100111, 3'b000, 1'b0, 0, 0, 5, 1, 2, 1);
`ifdef ILLEGAL_INSTR_TRAP_EN
      run("illegal",   7'b0110111, 3'b000, 1'b0, 0, 0, 7, 0, 1, 0);
      reset_seq();
`else
      run("illegal",   7'b0110111, 3'b000, 1'b0, 0, 0, 3, 0, 1, 1);
`endif
      run("after_ill", 7'b0110011, 3'b000, 1'b0, 0, 0, 4, 1, 1, 1);

      // Abandon a load while it waits in MEMREAD
      q.delete();
      build(7'b0000011, 3'b010, 1'b0, 0, 3);
      i_op = 7'b0000011;
      drive("load_abort", 4, rw, pcw, done);
      check("load_abort reg_write count", 32'(rw), 32'd0);
      check("load_abort retire count", 32'(done), 32'd0);
      reset_seq();
      run("post_abort", 7'b0110011, 3'b000, 1'b0, 0, 0, 4, 1, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over several cycles, driving datapath mux selects, write enables and ALU op class.
- Stalls on a single shared instruction/data memory port through a ready handshake.
- Sits beside the immediate-source decoder and ALU decoder; the PC-write logic lives here.

Parameters:
OP_WIDTH, 7, opcode field width
FUNC3_WIDTH, 3, funct3 field width

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  synchronous reset, active-low
i_op  in  7  opcode of instruction register
i_func3  in  3  funct3 of instruction register
i_zero  in  1  ALU zero flag
i_mem_ready  in  1  memory access complete this cycle
o_mem_req  out  1  memory access request
o_mem_write  out  1  store strobe (valid with o_mem_req)
o_adr_src  out  1  0=PC, 1=ALUOut
o_ir_write  out  1  instruction/old-PC register load
o_pc_write  out  1  PC register load
o_reg_write  out  1  register file write enable
o_result_src  out  2  00=ALUOut, 01=read data, 10=ALU result
o_alu_src_a  out  2  00=PC, 01=old PC, 10=rs1
o_alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
o_alu_op  out  2  00=add, 01=sub, 10=decode by funct
o_instr_done  out  1  one-cycle retire pulse
o_illegal  out  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Moore FSM; outputs decoded combinationally from the state, except where gated by i_mem_ready or i_zero.
- Reset: state=FETCH at the next edge while i_rst_n=0. While i_rst_n=0, o_pc_write, o_ir_write, o_reg_write, o_mem_write, o_mem_req and o_instr_done are forced 0. Reset mid-instruction abandons it with no write.
- Unlisted outputs are 0/00 in every state.
- FETCH: o_mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
  - When i_mem_ready=1: o_ir_write=1 and o_pc_write=1 (PC<=PC+4), then go to DECODE.
  - Otherwise hold state, with no writes.
- DECODE: src_a=01, src_b=01, alu_op=00 (ALUOut<=branch/JAL target). Next state by i_op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_CALC
  - other -> ILLEGAL
- MEMADR: src_a=10, src_b=01, alu_op=00. Next: MEMWRITE if i_op[5]=1, else MEMREAD.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Go to MEMWB when i_mem_ready, else hold.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. When i_mem_ready: instr_done=1, go to FETCH; else hold with mem_write held high.
- EXEC_R: src_a=10, src_b=00, alu_op=10. Next: ALUWB.
- EXEC_I: src_a=10, src_b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00.
  - taken = i_zero XOR i_func3[0] (BEQ/BNE); other funct3 values are treated per that same rule.
  - o_pc_write = taken; instr_done=1.
  - Next: FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1 (PC<=target). Next: ALUWB (rd<=oldPC+4).
- JALR_CALC: src_a=10, src_b=01, alu_op=00 (ALUOut<=rs1+imm). Next: JALR_JUMP.
- JALR_JUMP: result_src=00, pc_write=1, src_a=01, src_b=10, alu_op=00. Next: ALUWB.
- ILLEGAL: behaviour set by the macro.
- Latencies with zero memory wait:
  - load: 5 cycles
  - store, R/I-type, JAL: 4 cycles
  - branch: 3 cycles
  - JALR: 5 cycles
  - Each memory wait cycle adds one cycle.
- i_mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Optional Feature:
Macro ILLEGAL_INSTR_TRAP_EN.
- Defined: ILLEGAL is terminal. o_illegal=1 and all writes stay 0 until reset; o_illegal resets to 0.
- Undefined: ILLEGAL behaves as a NOP. instr_done=1, next state FETCH; o_illegal is tied 0.

Decomposition:
- Package ctrl_pkg holds:
  - state enum t_state
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR)
  - encodings for result_src, alu_src_a/b and alu_op
- One sub-module, ctrl_out_decoder: purely combinational state->output table, excluding the ready/zero gating.

Test Plan:
1. Reset held 3 cycles with i_mem_ready=1, then released -> no write strobes during reset; FETCH, ir_write and pc_write asserted on the first cycle after release.
2. R-type (op=0110011), ready always 1 -> states FETCH, DECODE, EXEC_R, ALUWB; reg_write=1 only in cycle 4; instr_done once.
3. Load (op=0000011), ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles with adr_src=1, then MEMWB with result_src=01 and reg_write=1; total 7 cycles.
4. BNE (func3=001) with i_zero=0, then i_zero=1 -> pc_write=1 in BRANCH, then 0; both return to FETCH after 3 cycles.
5. JALR (op=1100111) -> JALR_CALC, JALR_JUMP with pc_write=1 and result_src=00, then ALUWB with reg_write=1.
6. op=0110111 -> with ILLEGAL_INSTR_TRAP_EN, o_illegal=1 permanently with no further writes until reset; without it, instr_done pulses and FETCH follows.
